tl_arb_mux: RTL and testbench



---
 rtl/tl_pkg.sv | 14 +
 rtl/tl_rr_pick.sv | 41 ++++
 rtl/tl_arb_mux.sv | 138 +++++++++++++
 tb/tb_tl_arb_mux.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared constants for the transaction-layer arbitration multiplexer.
package tl_pkg;

    // Arbitration mode selectors for the ARB_MODE parameter
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Main arbiter state: no holder, or a channel holding a burst
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } tl_state_e;

endpackage : tl_pkg

// File: rtl/tl_rr_pick.sv
// Combinational next-eligible picker.
// In round-robin mode the search starts one past ptr_i and wraps, so the
// channel at ptr_i itself has the lowest priority. In fixed mode the lowest
// requesting index wins and ptr_i is ignored.
module tl_rr_pick #(
    parameter int NUM_CH = 4,
    parameter int IW     = 2
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IW-1:0]     ptr_i,
    input  logic              fixed_i,
    output logic              valid_o,
    output logic [IW-1:0]     idx_o
);

    int          cand_s;
    logic [IW-1:0] cand_idx_s;

    // Scan from the farthest candidate to the nearest so the nearest hit wins
    always_comb begin
        valid_o    = 1'b0;
        idx_o      = '0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (fixed_i) begin
                cand_s = k - 1;
            end else begin
                cand_s = (int'(ptr_i) + k) % NUM_CH;
            end
            cand_idx_s = IW'(cand_s);
            if (req_i[cand_idx_s]) begin
                valid_o = 1'b1;
                idx_o   = cand_idx_s;
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule : tl_rr_pick

// File: rtl/tl_arb_mux.sv
// N-channel multiplexer draining first-word-fall-through FIFOs into one
// downstream FIFO, with round-robin or fixed-priority arbitration, a bounded
// per-grant burst length and almost-full / active gating.
module tl_arb_mux
    import tl_pkg::*;
#(
    parameter int  NUM_CH    = 4,
    parameter int  DATA_W    = 10,
    parameter int  MAX_BURST = 4,
    parameter int  ARB_MODE  = 0,
    localparam int IW        = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     active,
    input  logic [NUM_CH-1:0]        in_empty,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_pop,
    input  logic                     out_almost_full,
    output logic                     out_push,
    output logic [DATA_W-1:0]        out_data,
    output logic [IW-1:0]            grant_id
);

    localparam int   CW         = $clog2(MAX_BURST + 1);
    localparam logic MODE_FIXED = (ARB_MODE == ARB_FIXED);

    tl_state_e         state_q, state_d;
    logic [IW-1:0]     hold_q, hold_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic              out_push_q;
    logic [DATA_W-1:0] out_data_q;
    logic [IW-1:0]     grant_q;

    logic [NUM_CH-1:0] elig_s;
    logic              go_s;
    logic              cont_s;
    logic              pick_valid_s;
    logic [IW-1:0]     pick_idx_s;
    logic              pop_any_s;
    logic [IW-1:0]     pop_idx_s;
    logic [DATA_W-1:0] word_s [NUM_CH];

    assign elig_s = ~in_empty;
    // Reset is folded into go so nothing is popped while reset is asserted.
    assign go_s   = active & ~out_almost_full & ~reset;
    assign cont_s = (state_q == ST_HOLD) && elig_s[hold_q] &&
                    (cnt_q < CW'(MAX_BURST));

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign word_s[g] = in_data[g*DATA_W +: DATA_W];
    end

    tl_rr_pick #(
        .NUM_CH (NUM_CH),
        .IW     (IW)
    ) u_pick (
        .req_i   (elig_s),
        .ptr_i   (ptr_q),
        .fixed_i (MODE_FIXED),
        .valid_o (pick_valid_s),
        .idx_o   (pick_idx_s)
    );

    // Next-state: continue the burst, rearbitrate, or fall back to IDLE
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        pop_any_s = 1'b0;
        pop_idx_s = hold_q;
        if (go_s) begin
            if (cont_s) begin
                pop_any_s = 1'b1;
                pop_idx_s = hold_q;
                cnt_d     = cnt_q + CW'(1);
            end else if (pick_valid_s) begin
                pop_any_s = 1'b1;
                pop_idx_s = pick_idx_s;
                state_d   = ST_HOLD;
                hold_d    = pick_idx_s;
                cnt_d     = CW'(1);
                ptr_d     = pick_idx_s;
            end else begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end else if (!active) begin
            // Leaving ACTIVE aborts any burst; the RR pointer survives.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            state_d = state_q;
        end
    end

    assign in_pop = pop_any_s ? (NUM_CH'(1) << pop_idx_s) : '0;

    // Arbiter state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
            ptr_q   <= IW'(NUM_CH - 1);
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // Output registers: push the popped word one cycle after the pop
    always_ff @(posedge clk) begin
        if (reset) begin
            out_push_q <= 1'b0;
            out_data_q <= '0;
            grant_q    <= '0;
        end else begin
            out_push_q <= pop_any_s;
            if (pop_any_s) begin
                out_data_q <= word_s[pop_idx_s];
                grant_q    <= pop_idx_s;
            end else begin
                out_data_q <= out_data_q;
                grant_q    <= grant_q;
            end
        end
    end

    assign out_push = out_push_q;
    assign out_data = out_data_q;
    assign grant_id = grant_q;

endmodule : tl_arb_mux

// File: tb/tb_tl_arb_mux.sv
// Scoreboard bench for tl_arb_mux: a burst-4 round-robin instance driven by
// modelled FIFOs, plus burst-1 round-robin and fixed-priority instances fed
// by always-non-empty channels.
module tb_tl_arb_mux;

    logic        clk;
    logic        reset;
    logic        active;
    logic        active_aux;
    logic        afull;
    logic [3:0]  in_empty;
    logic [39:0] in_data;
    logic [3:0]  in_pop;
    logic        out_push;
    logic [9:0]  out_data;
    logic [1:0]  grant_id;

    logic [3:0]  aux_empty;
    logic [39:0] aux_data;
    logic        aux_afull;
    logic [3:0]  pop_rr1, pop_fx;
    logic        push_rr1, push_fx;
    logic [9:0]  data_rr1, data_fx;
    logic [1:0]  grant_rr1, grant_fx;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [9:0]  fmem [4][16];
    int          fhd [4];
    int          ftl [4];
    logic [3:0]  pop_s;

    logic [11:0] q_m[$];
    logic [11:0] q_r[$];
    logic [11:0] q_f[$];

    tl_arb_mux #(.NUM_CH(4), .DATA_W(10), .MAX_BURST(4), .ARB_MODE(0)) u_dut (
        .clk(clk), .reset(reset), .active(active), .in_empty(in_empty),
        .in_data(in_data), .in_pop(in_pop), .out_almost_full(afull),
        .out_push(out_push), .out_data(out_data), .grant_id(grant_id));

    tl_arb_mux #(.NUM_CH(4), .DATA_W(10), .MAX_BURST(1), .ARB_MODE(0)) u_rr1 (
        .clk(clk), .reset(reset), .active(active_aux), .in_empty(aux_empty),
        .in_data(aux_data), .in_pop(pop_rr1), .out_almost_full(aux_afull),
        .out_push(push_rr1), .out_data(data_rr1), .grant_id(grant_rr1));

    tl_arb_mux #(.NUM_CH(4), .DATA_W(10), .MAX_BURST(1), .ARB_MODE(1)) u_fx (
        .clk(clk), .reset(reset), .active(active_aux), .in_empty(aux_empty),
        .in_data(aux_data), .in_pop(pop_fx), .out_almost_full(aux_afull),
        .out_push(push_fx), .out_data(data_fx), .grant_id(grant_fx));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] oh2i(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) r = 2'(i);
        end
        return r;
    endfunction

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            in_empty[i] = (fhd[i] == ftl[i]);
            in_data[i*10 +: 10] = (fhd[i] == ftl[i]) ? 10'h000 : fmem[i][fhd[i]];
        end
    endtask

    task automatic load(input int c, input logic [9:0] w);
        fmem[c][ftl[c]] = w;
        ftl[c] = ftl[c] + 1;
    endtask

    // One cycle: check pops at negedge, queue expected pushes, retire pops after the edge
    task automatic tick(input logic [3:0] p, input logic [9:0] d,
                        input logic [3:0] p1, input logic [3:0] pf);
        logic [1:0] i1, i2;
        @(negedge clk);
        chk("main_in_pop", {28'd0, in_pop}, {28'd0, p});
        chk("rr1_in_pop", {28'd0, pop_rr1}, {28'd0, p1});
        chk("fx_in_pop", {28'd0, pop_fx}, {28'd0, pf});
        i1 = oh2i(p1);
        i2 = oh2i(pf);
        if (p != 4'd0) q_m.push_back({oh2i(p), d});
        if (p1 != 4'd0) q_r.push_back({i1, 8'hE8, i1});
        if (pf != 4'd0) q_f.push_back({i2, 8'hE8, i2});
        pop_s = in_pop;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (pop_s[i] && (fhd[i] != ftl[i])) fhd[i] = fhd[i] + 1;
        end
        refresh();
    endtask

    // Main-instance monitor
    always @(negedge clk) begin
        logic [11:0] e;
        if (out_push === 1'b1) begin
            if (q_m.size() == 0) begin
                vec_cnt++; err_cnt++;
                $display("FAIL main_push: got unexpected push data 0x%0h expected none", out_data);
            end else begin
                e = q_m.pop_front();
                chk("main_data", {22'd0, out_data}, {22'd0, e[9:0]});
                chk("main_grant", {30'd0, grant_id}, {30'd0, e[11:10]});
            end
        end
    end

    // Burst-1 round-robin monitor
    always @(negedge clk) begin
        logic [11:0] e;
        if (push_rr1 === 1'b1) begin
            if (q_r.size() == 0) begin
                vec_cnt++; err_cnt++;
                $display("FAIL rr1_push: got unexpected push data 0x%0h expected none", data_rr1);
            end else begin
                e = q_r.pop_front();
                chk("rr1_data", {22'd0, data_rr1}, {22'd0, e[9:0]});
                chk("rr1_grant", {30'd0, grant_rr1}, {30'd0, e[11:10]});
            end
        end
    end

    // Fixed-priority monitor
    always @(negedge clk) begin
        logic [11:0] e;
        if (push_fx === 1'b1) begin
            if (q_f.size() == 0) begin
                vec_cnt++; err_cnt++;
                $display("FAIL fx_push: got unexpected push data 0x%0h expected none", data_fx);
            end else begin
                e = q_f.pop_front();
                chk("fx_data", {22'd0, data_fx}, {22'd0, e[9:0]});
                chk("fx_grant", {30'd0, grant_fx}, {30'd0, e[11:10]});
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            fhd[i] = 0;
            ftl[i] = 0;
        end
        aux_empty  = 4'b0000;
        aux_data   = {10'h3A3, 10'h3A2, 10'h3A1, 10'h3A0};
        aux_afull  = 1'b0;
        reset      = 1'b1;
        active     = 1'b1;
        active_aux = 1'b1;
        afull      = 1'b0;
        pop_s      = 4'd0;
        refresh();

        // Reset held two cycles with aux channels non-empty and active
        tick(4'd0, 10'h0, 4'd0, 4'd0);
        tick(4'd0, 10'h0, 4'd0, 4'd0);
        chk("reset_push", {31'd0, out_push}, 32'd0);
        chk("reset_data", {22'd0, out_data}, 32'd0);
        chk("reset_grant", {30'd0, grant_id}, 32'd0);
        chk("reset_rr1_push", {31'd0, push_rr1}, 32'd0);
        reset      = 1'b0;
        active_aux = 1'b0;

        // Burst limit: ch0 x4, ch2 x2, ch0 x2 back to back
        for (int k = 0; k < 6; k++) load(0, 10'h011 + 10'(k));
        load(2, 10'h221);
        load(2, 10'h222);
        refresh();
        tick(4'd1, 10'h011, 4'd0, 4'd0);
        tick(4'd1, 10'h012, 4'd0, 4'd0);
        tick(4'd1, 10'h013, 4'd0, 4'd0);
        tick(4'd1, 10'h014, 4'd0, 4'd0);
        tick(4'd4, 10'h221, 4'd0, 4'd0);
        tick(4'd4, 10'h222, 4'd0, 4'd0);
        tick(4'd1, 10'h015, 4'd0, 4'd0);
        tick(4'd1, 10'h016, 4'd0, 4'd0);
        tick(4'd0, 10'h0, 4'd0, 4'd0);

        // Single channel ch1
        load(1, 10'h102);
        load(1, 10'h112);
        load(1, 10'h122);
        refresh();
        tick(4'd2, 10'h102, 4'd0, 4'd0);
        tick(4'd2, 10'h112, 4'd0, 4'd0);
        tick(4'd2, 10'h122, 4'd0, 4'd0);
        tick(4'd0, 10'h0, 4'd0, 4'd0);
        chk("single_grant", {30'd0, grant_id}, 32'd1);

        // Backpressure in a ch3 burst; count resumes so ch0 interleaves after 4 ch3 words
        for (int k = 0; k < 5; k++) load(3, 10'h331 + 10'(k));
        load(0, 10'h017);
        refresh();
        tick(4'd8, 10'h331, 4'd0, 4'd0);
        tick(4'd8, 10'h332, 4'd0, 4'd0);
        afull = 1'b1;
        tick(4'd0, 10'h0, 4'd0, 4'd0);
        tick(4'd0, 10'h0, 4'd0, 4'd0);
        tick(4'd0, 10'h0, 4'd0, 4'd0);
        afull = 1'b0;
        tick(4'd8, 10'h333, 4'd0, 4'd0);
        tick(4'd8, 10'h334, 4'd0, 4'd0);
        tick(4'd1, 10'h017, 4'd0, 4'd0);
        tick(4'd8, 10'h335, 4'd0, 4'd0);
        tick(4'd0, 10'h0, 4'd0, 4'd0);

        // Active drop mid-burst on ch0: rearbitration from ptr=0 picks ch1
        for (int k = 0; k < 4; k++) load(0, 10'h041 + 10'(k));
        load(1, 10'h141);
        load(1, 10'h142);
        refresh();
        tick(4'd1, 10'h041, 4'd0, 4'd0);
        tick(4'd1, 10'h042, 4'd0, 4'd0);
        active = 1'b0;
        tick(4'd0, 10'h0, 4'd0, 4'd0);
        active = 1'b1;
        tick(4'd2, 10'h141, 4'd0, 4'd0);
        tick(4'd2, 10'h142, 4'd0, 4'd0);
        tick(4'd1, 10'h043, 4'd0, 4'd0);
        tick(4'd1, 10'h044, 4'd0, 4'd0);
        tick(4'd0, 10'h0, 4'd0, 4'd0);

        // Reset mid-burst on ch2
        for (int k = 0; k < 4; k++) load(2, 10'h251 + 10'(k));
        refresh();
        tick(4'd4, 10'h251, 4'd0, 4'd0);
        tick(4'd4, 10'h252, 4'd0, 4'd0);
        reset = 1'b1;
        tick(4'd0, 10'h0, 4'd0, 4'd0);
        chk("midreset_push", {31'd0, out_push}, 32'd0);
        chk("midreset_data", {22'd0, out_data}, 32'd0);
        chk("midreset_grant", {30'd0, grant_id}, 32'd0);
        reset = 1'b0;
        tick(4'd4, 10'h253, 4'd0, 4'd0);
        tick(4'd4, 10'h254, 4'd0, 4'd0);
        tick(4'd0, 10'h0, 4'd0, 4'd0);

        // Rotation with burst 1: RR gives 0,1,2,3,0,1; fixed always 0
        active_aux = 1'b1;
        tick(4'd0, 10'h0, 4'd1, 4'd1);
        tick(4'd0, 10'h0, 4'd2, 4'd1);
        tick(4'd0, 10'h0, 4'd4, 4'd1);
        tick(4'd0, 10'h0, 4'd8, 4'd1);
        tick(4'd0, 10'h0, 4'd1, 4'd1);
        tick(4'd0, 10'h0, 4'd2, 4'd1);
        active_aux = 1'b0;
        tick(4'd0, 10'h0, 4'd0, 4'd0);
        tick(4'd0, 10'h0, 4'd0, 4'd0);

        // Every expected push must have been seen
        chk("main_drain", q_m.size(), 32'd0);
        chk("rr1_drain", q_r.size(), 32'd0);
        chk("fx_drain", q_f.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_tl_arb_mux
